// File: rtl/video_timing_gen.sv
// Raster timing generator: free-running h/v counters with registered sync, blank,
// pixel coordinates, linear active-pixel index and a frame-start pulse.
module video_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int POS_W    = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_blank,
    output logic [10:0]      o_pixel_x,
    output logic [9:0]       o_pixel_y,
    output logic [POS_W-1:0] o_pixel_pos,
    output logic             o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT_C  = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);

    logic [10:0]      h_cnt_reg;
    logic [9:0]       v_cnt_reg;
    logic [POS_W-1:0] pos_cnt_reg;
    logic [POS_W-1:0] pos_cur;
    logic             h_last;
    logic             v_last;
    logic             origin;
    logic             active;
    logic             hs_on;
    logic             vs_on;

    always_comb begin
        h_last  = (h_cnt_reg == H_LAST);
        v_last  = (v_cnt_reg == V_LAST);
        origin  = (h_cnt_reg == 11'd0) && (v_cnt_reg == 10'd0);
        active  = (h_cnt_reg < H_ACT_C) && (v_cnt_reg < V_ACT_C);
        hs_on   = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
        vs_on   = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);
        // The running index restarts at the frame origin, so pixel (0,0) shows 0.
        pos_cur = origin ? '0 : pos_cnt_reg;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt_reg   <= '0;
            v_cnt_reg   <= '0;
            pos_cnt_reg <= '0;
        end else if (i_en) begin
            h_cnt_reg <= h_last ? 11'd0 : h_cnt_reg + 11'd1;
            if (h_last) begin
                v_cnt_reg <= v_last ? 10'd0 : v_cnt_reg + 10'd1;
            end
            pos_cnt_reg <= active ? pos_cur + POS_W'(1) : pos_cur;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hsync       <= ~HS_POL;
            o_vsync       <= ~VS_POL;
            o_blank       <= 1'b1;
            o_pixel_x     <= '0;
            o_pixel_y     <= '0;
            o_pixel_pos   <= '0;
            o_frame_start <= 1'b0;
        end else if (i_en) begin
            o_hsync       <= hs_on ? HS_POL : ~HS_POL;
            o_vsync       <= vs_on ? VS_POL : ~VS_POL;
            o_blank       <= ~active;
            o_pixel_x     <= h_cnt_reg;
            o_pixel_y     <= v_cnt_reg;
            o_pixel_pos   <= active ? pos_cur : '0;
            o_frame_start <= origin;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen using a reduced raster so whole frames fit in a short run;
// expected outputs come from the count of enabled edges since reset.
module tb_video_timing_gen;

    localparam int HA = 16, HFP = 4, HSY = 6, HBP = 5;
    localparam int VA = 8, VFP = 1, VSY = 2, VBP = 3;
    localparam bit HSP = 1'b1, VSP = 1'b0;
    localparam int PW = 8;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic          hsync, vsync, blank, frame_start;
    logic [10:0]   pixel_x;
    logic [9:0]    pixel_y;
    logic [PW-1:0] pixel_pos;

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;    // enabled edges since the last reset
    int frames  = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .POS_W(PW)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en),
        .o_hsync(hsync), .o_vsync(vsync), .o_blank(blank),
        .o_pixel_x(pixel_x), .o_pixel_y(pixel_y),
        .o_pixel_pos(pixel_pos), .o_frame_start(frame_start)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (k=%0d)", tag, got, exp, k);
        end
    endtask

    // Output k enabled edges after reset shows raster position (k-1) mod FRAME.
    task automatic check_all(input string ph);
        int  n, x, y, pos;
        bit  act, hs, vs, fs;
        if (k == 0) begin
            x = 0; y = 0; pos = 0; act = 1'b0; hs = 1'b0; vs = 1'b0; fs = 1'b0;
        end else begin
            n   = (k - 1) % FRAME;
            x   = n % HT;
            y   = n / HT;
            act = (x < HA) && (y < VA);
            pos = act ? y * HA + x : 0;
            hs  = (x >= HA + HFP) && (x < HA + HFP + HSY);
            vs  = (y >= VA + VFP) && (y < VA + VFP + VSY);
            fs  = (n == 0);
        end
        check_eq({ph, ".x"},     32'(pixel_x),     32'(x));
        check_eq({ph, ".y"},     32'(pixel_y),     32'(y));
        check_eq({ph, ".blank"}, 32'(blank),       32'(!act));
        check_eq({ph, ".hsync"}, 32'(hsync),       32'(hs ? HSP : !HSP));
        check_eq({ph, ".vsync"}, 32'(vsync),       32'(vs ? VSP : !VSP));
        check_eq({ph, ".pos"},   32'(pixel_pos),   32'(pos));
        check_eq({ph, ".fs"},    32'(frame_start), 32'(fs));
        if (k != 0 && x == HA - 1 && y == VA - 1)
            check_eq({ph, ".pos_max"}, 32'(pixel_pos), 32'(HA * VA - 1));
    endtask

    // Called at a negedge: apply inputs, take one rising edge, check at next negedge.
    task automatic step(input bit e, input string ph);
        en = e;
        @(posedge clk);
        if (e && rst_n) k++;
        @(negedge clk);
        check_all(ph);
        if (k != 0 && e && rst_n && (k - 1) % FRAME == 0) begin
            frames++;
            $display("[TB] %s: frame start #%0d at k=%0d", ph, frames, k);
        end
    endtask

    task automatic async_reset(input string ph);
        #2 rst_n = 1'b0;
        #1 k = 0;
        check_all({ph, ".arst"});
        $display("[TB] %s: asynchronous reset applied", ph);
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        bit seen;
        @(negedge clk);
        $display("[TB] reset held with enable high");
        for (int i = 0; i < 3; i++) step(1'b1, "rst");
        rst_n = 1'b1;

        // First edge out of reset gives pixel (0,0); then measure the frame period.
        step(1'b1, "first");
        cnt = 0; seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            step(1'b1, "period");
            cnt++;
            if (frame_start) seen = 1'b1;
        end
        check_eq("frame_period", 32'(cnt), 32'(FRAME));
        $display("[TB] frame period measured: %0d clocks", cnt);

        // Enable dropped while frame_start is high must not re-pulse.
        async_reset("fs_hold");
        rst_n = 1'b1;
        step(1'b1, "fs_hold");
        for (int i = 0; i < 5; i++) step(1'b0, "fs_hold");
        step(1'b1, "fs_hold");
        check_eq("fs_no_repulse", 32'(frame_start), 32'(0));

        // Randomised enable with occasional mid-frame asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset("rand");
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) step(1'b1, "rand_rst");
                rst_n = 1'b1;
            end
            step($urandom_range(0, 9) < 8, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Generates raster timing for the HDMI output path: horizontal/vertical counters, sync pulses, blanking and pixel position. It sits directly upstream of the RGB pattern stage and drives that stage's i_hsync, i_vsync, i_blank and i_pixel_pos. The defaults give 800x600@60 (40 MHz pixel clock). All outputs are registered and mutually aligned.

Parameters:
H_ACTIVE, 800, active pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 128, horizontal sync width (clocks)
H_BP, 88, horizontal back porch (clocks)
V_ACTIVE, 600, active lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level
POS_W, 20, width of o_pixel_pos

Ports:
i_clk  in  1  pixel clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  advance enable (e.g. from PLL lock); when low, timing freezes
o_hsync  out  1  horizontal sync, level HS_POL when asserted
o_vsync  out  1  vertical sync, level VS_POL when asserted
o_blank  out  1  1 = outside the active area
o_pixel_x  out  11  horizontal counter value
o_pixel_y  out  10  vertical counter value
o_pixel_pos  out  POS_W  linear active-pixel index, y*H_ACTIVE+x
o_frame_start  out  1  one-cycle pulse at pixel (0,0)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
- Internal h_cnt runs 0..H_TOTAL-1. v_cnt runs 0..V_TOTAL-1.
- When i_en=1, h_cnt increments every clock. At h_cnt=H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. When h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, both wrap to 0.
- When i_en=0, the counters and all outputs hold their values. This includes o_frame_start: if it was 1, it stays 1 and does not re-pulse.
- Output registers load from the current counter values every enabled clock. Outputs therefore lag the counters by exactly 1 cycle and are all aligned with each other.
- o_pixel_x and o_pixel_y carry the raw h_cnt and v_cnt values.
- blank = !(h_cnt < H_ACTIVE && v_cnt < V_ACTIVE).
- hsync is asserted when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (840..967).
- vsync is asserted when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (601..604), for whole lines including their full horizontal span.
- o_pixel_pos comes from an internal running counter; no multiplier is used.
  - The counter is cleared to 0 when h_cnt=0 and v_cnt=0.
  - It increments after each active pixel.
  - o_pixel_pos shows the running value while o_blank=0 and is driven to 0 while o_blank=1.
  - Its maximum is H_ACTIVE*V_ACTIVE-1 (479999). The counter must not overflow POS_W.
- o_frame_start = 1 exactly when the output reflects h_cnt=0 and v_cnt=0. It is asserted for one cycle per frame.
- Reset, asynchronous on i_rst_n low, from any state including mid-frame:
  - h_cnt=0, v_cnt=0, running pos=0.
  - o_hsync=!HS_POL, o_vsync=!VS_POL, o_blank=1.
  - o_pixel_x=0, o_pixel_y=0, o_pixel_pos=0, o_frame_start=0.
- After reset: the first enabled edge presents pixel (0,0), with o_blank=0, o_frame_start=1 and o_pixel_pos=0. Counters advance to h_cnt=1 on the same edge.
- Frame period: H_TOTAL*V_TOTAL = 663168 enabled clocks between o_frame_start pulses.
- Parameter rule: the sync window must lie inside the blanking region. H_TOTAL must be <= 2048 and V_TOTAL <= 1024.

Test Plan:
- Reset/first pixel: hold i_rst_n low with i_en=1 -> outputs at their reset values (hsync=0, vsync=0, blank=1). On release, the first edge gives x=0, y=0, blank=0, frame_start=1, pos=0.
- Line timing, line 0: blank rises when o_pixel_x goes 799->800; hsync is high for exactly 128 clocks while o_pixel_x is 840..967; x wraps 1055->0 and y increments to 1.
- Frame timing: vsync is high for 4*1056 clocks while o_pixel_y is 601..604; blank stays 1 for lines 600..627; frame_start pulses again exactly 663168 clocks after the first pulse.
- Pixel index: at (x=799, y=599), o_pixel_pos=479999; at (x=0, y=1), it is 800; during the next blank, o_pixel_pos=0; at the next (0,0), it is 0.
- Enable gating: drop i_en for 10 clocks at x=500, y=10 -> all outputs hold, and resuming gives x=501. Drop i_en while frame_start=1 -> no second pulse after resuming.
- Mid-frame reset: assert i_rst_n low at x=900, y=300 -> outputs take their reset values immediately (asynchronously). After release, timing restarts at (0,0) with frame_start=1.
